// File: rtl/iob_vga_ctrl_pkg.sv
// Shared helpers for the VGA controller.
// Contents:
//   cnt_width  - bits needed to hold the values 0..max_val
//   sync_level - drive level of a sync output given its region flag and active polarity
package iob_vga_ctrl_pkg;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Active polarity inside the sync pulse, the inverse everywhere else.
  function automatic logic sync_level(input logic in_region, input logic pol);
    return in_region ? pol : ~pol;
  endfunction

endpackage

// File: rtl/iob_vga_ctrl.vh
// Derived VGA timing constants. Included inside the body of a module that declares
// the H_*/V_* timing parameters and PRESCALE, and imports iob_vga_ctrl_pkg.
localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
// Counter widths can hold the totals themselves so every boundary compares without truncation.
localparam int unsigned HCNT_W       = cnt_width(H_TOTAL);
localparam int unsigned VCNT_W       = cnt_width(V_TOTAL);
localparam int unsigned PRE_W        = cnt_width(PRESCALE);

// File: rtl/iob_vga_timing.sv
// VGA raster timing: pixel prescaler plus horizontal/vertical counters and region flags.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - timing enable; low holds everything at the frame origin
//   tick              - pixel tick, one clk per PRESCALE clks while enabled
//   active            - current position lies in the visible area
//   h_region/v_region - current position lies inside the horizontal/vertical sync pulse
//   origin            - current position is (0,0)
module iob_vga_timing
  import iob_vga_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic active,
  output logic h_region,
  output logic v_region,
  output logic origin
);

  `include "iob_vga_ctrl.vh"

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    // Reset masks the tick so no pixel request escapes during the reset clk.
    tick   = en && !rst && (pre_q == PRE_W'(PRESCALE - 1));
    pre_d  = pre_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en) begin
      pre_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (hcnt_q == HCNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VCNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + VCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    active   = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
    h_region = (hcnt_q >= HCNT_W'(H_SYNC_START)) && (hcnt_q < HCNT_W'(H_SYNC_END));
    v_region = (vcnt_q >= VCNT_W'(V_SYNC_START)) && (vcnt_q < VCNT_W'(V_SYNC_END));
    origin   = (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      pre_q  <= pre_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/iob_vga_ctrl.sv
// VGA controller: scans a linear RGB565 frame buffer and drives sync, data-enable and
// reduced-width colour outputs.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   en                        - timing enable
//   fb_base, fb_base_wr       - frame-buffer base word address and its write strobe
//   pixel_ren, pixel_addr     - pixel read request (one clk per visible pixel)
//   pixel                     - read data, valid the clk after pixel_ren
//   h_sync, v_sync, de        - registered sync and data-enable outputs
//   red, green, blue          - colour outputs (MSBs of each RGB565 field), 0 in blanking
//   frame_start               - one-clk pulse with the output update for position (0,0)
module iob_vga_ctrl
  import iob_vga_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PIXEL_W  = 16,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ADDR_W-1:0]  fb_base,
  input  logic               fb_base_wr,
  output logic               pixel_ren,
  output logic [ADDR_W-1:0]  pixel_addr,
  input  logic [PIXEL_W-1:0] pixel,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start
);

  logic tick, active, h_region, v_region, origin;

  iob_vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PRESCALE (PRESCALE)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick     (tick),
    .active   (active),
    .h_region (h_region),
    .v_region (v_region),
    .origin   (origin)
  );

  logic [ADDR_W-1:0]  pend_q, base_q, off_q, base_cur, off_cur;
  logic               load_q, de_q, h_sync_q, v_sync_q, frame_start_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q, red_px, green_px, blue_px;
  logic               unused_pixel;

  always_comb begin
    // At the frame origin the pending base takes effect in the same clk, and the
    // offset restarts; elsewhere the offset just advances one word per visible pixel.
    base_cur   = origin ? pend_q : base_q;
    off_cur    = origin ? '0 : off_q;
    pixel_ren  = tick && active;
    pixel_addr = base_cur + off_cur;

    red_px     = pixel[15 -: COLOR_W];
    green_px   = pixel[10 -: COLOR_W];
    blue_px    = pixel[4 -: COLOR_W];

    // Read data is only valid the clk after pixel_ren: pass it straight through then
    // and serve the captured copy for the rest of the pixel period.
    red         = load_q ? red_px   : red_q;
    green       = load_q ? green_px : green_q;
    blue        = load_q ? blue_px  : blue_q;
    de          = de_q;
    h_sync      = h_sync_q;
    v_sync      = v_sync_q;
    frame_start = frame_start_q;
  end

  assign unused_pixel = ^pixel;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= '0;
      base_q        <= '0;
      off_q         <= '0;
      load_q        <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      if (fb_base_wr) pend_q <= fb_base;
      load_q        <= 1'b0;
      frame_start_q <= 1'b0;
      if (load_q) begin
        red_q   <= red_px;
        green_q <= green_px;
        blue_q  <= blue_px;
      end
      if (!en) begin
        de_q     <= 1'b0;
        h_sync_q <= ~HS_POL;
        v_sync_q <= ~VS_POL;
        red_q    <= '0;
        green_q  <= '0;
        blue_q   <= '0;
      end else if (tick) begin
        if (origin) base_q <= pend_q;
        if (active) off_q <= off_cur + ADDR_W'(1);
        load_q        <= active;
        de_q          <= active;
        frame_start_q <= origin;
        h_sync_q      <= sync_level(h_region, HS_POL);
        v_sync_q      <= sync_level(v_region, VS_POL);
        if (!active) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_vga_ctrl.sv
// Bench for iob_vga_ctrl: two instances (PRESCALE 1 and 3) share random stimulus; a
// position/frame reference model pushes expected requests and outputs into per-instance
// queues, and a negedge monitor pops and compares them.
module tb_iob_vga_ctrl;

  localparam int unsigned HA = 4, HF = 1, HSW = 2, HBP = 1;
  localparam int unsigned VA = 3, VF = 1, VSW = 1, VBP = 1;
  localparam int unsigned HT = HA + HF + HSW + HBP;
  localparam int unsigned VT = VA + VF + VSW + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned P0 = 1, P1 = 3;
  localparam int NI = 2;

  typedef struct packed {
    logic de; logic hs; logic vs; logic fs;
    logic [3:0] r; logic [3:0] g; logic [3:0] b;
  } out_t;
  typedef struct packed { int unsigned cyc; out_t o; } exp_out_t;
  typedef struct packed { int unsigned cyc; logic [31:0] a; } exp_ren_t;

  logic        clk = 1'b0;
  logic        rst, en, fb_base_wr, mem_const, started;
  logic [31:0] fb_base;
  logic        ren [NI];
  logic [31:0] addr [NI];
  logic [15:0] pix [NI];
  logic        hsy [NI], vsy [NI], de [NI], fs [NI];
  logic [3:0]  red [NI], grn [NI], blu [NI];

  int unsigned cyc;
  int          n_pass, n_total;
  int unsigned k [NI];
  logic [31:0] pend [NI], base [NI];
  out_t        nxt [NI];
  exp_out_t    oq [NI][$];
  exp_ren_t    rq [NI][$];

  always #5 clk = ~clk;

  iob_vga_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PRESCALE(P0), .PIXEL_W(16), .COLOR_W(4), .ADDR_W(32)
  ) dut_p1 (
    .clk(clk), .rst(rst), .en(en), .fb_base(fb_base), .fb_base_wr(fb_base_wr),
    .pixel_ren(ren[0]), .pixel_addr(addr[0]), .pixel(pix[0]),
    .h_sync(hsy[0]), .v_sync(vsy[0]), .de(de[0]),
    .red(red[0]), .green(grn[0]), .blue(blu[0]), .frame_start(fs[0])
  );

  iob_vga_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PRESCALE(P1), .PIXEL_W(16), .COLOR_W(4), .ADDR_W(32)
  ) dut_p3 (
    .clk(clk), .rst(rst), .en(en), .fb_base(fb_base), .fb_base_wr(fb_base_wr),
    .pixel_ren(ren[1]), .pixel_addr(addr[1]), .pixel(pix[1]),
    .h_sync(hsy[1]), .v_sync(vsy[1]), .de(de[1]),
    .red(red[1]), .green(grn[1]), .blue(blu[1]), .frame_start(fs[1])
  );

  function automatic int unsigned presc(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  // Frame-buffer contents: an address hash, or a fixed magenta word.
  function automatic logic [15:0] memf(input logic [31:0] a);
    if (mem_const) return 16'hF81F;
    return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // Memory answers one clk after the request; garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) pix[i] <= ren[i] ? memf(addr[i]) : 16'($urandom);
  end

  // Reference model for the current cycle's inputs. Position comes from the number of
  // enabled cycles: tick index t = k/P, h = t mod HT, v = (t div HT) mod VT.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int unsigned p, t, h, v;
      logic        act;
      logic [31:0] a;
      logic [15:0] px;
      exp_out_t    eo;
      exp_ren_t    er;
      p = presc(i);
      if (started) begin
        eo.cyc = cyc;
        eo.o   = nxt[i];
        oq[i].push_back(eo);
      end
      if (rst) begin
        k[i]    = 0;
        pend[i] = '0;
        base[i] = '0;
        nxt[i]  = idle_out();
      end else begin
        if (!en) begin
          k[i]   = 0;
          nxt[i] = idle_out();
        end else begin
          nxt[i].fs = 1'b0;
          if (k[i] % p == p - 1) begin
            t = k[i] / p;
            h = t % HT;
            v = (t / HT) % VT;
            if (h == 0 && v == 0) base[i] = pend[i];
            act = (h < HA) && (v < VA);
            a   = base[i] + 32'(v * HA + h);
            px  = memf(a);
            if (act) begin
              er.cyc = cyc;
              er.a   = a;
              rq[i].push_back(er);
            end
            nxt[i].de = act;
            nxt[i].hs = !(h >= HA + HF && h < HA + HF + HSW);
            nxt[i].vs = !(v >= VA + VF && v < VA + VF + VSW);
            nxt[i].fs = (h == 0 && v == 0);
            nxt[i].r  = act ? px[15:12] : 4'h0;
            nxt[i].g  = act ? px[10:7]  : 4'h0;
            nxt[i].b  = act ? px[4:1]   : 4'h0;
          end
          k[i]++;
        end
        if (fb_base_wr) pend[i] = fb_base;
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; the model is evaluated for that cycle.
  task automatic cycle();
    model_step();
    started = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    fb_base_wr = 1'b0;
  endtask

  function automatic logic origin_tick_now(input int i);
    return en && !rst && ((k[i] % (presc(i) * FRAME)) == presc(i) - 1);
  endfunction

  always @(negedge clk) begin
    logic     exp_ren;
    exp_out_t eo;
    exp_ren_t er;
    out_t     got;
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        exp_ren = (rq[i].size() > 0) && (rq[i][0].cyc == cyc);
        check($sformatf("pixel_ren p%0d @%0d", presc(i), cyc), 64'(ren[i]), 64'(exp_ren));
        if (exp_ren) begin
          er = rq[i].pop_front();
          check($sformatf("pixel_addr p%0d @%0d", presc(i), cyc), 64'(addr[i]), 64'(er.a));
        end
        if (oq[i].size() > 0 && oq[i][0].cyc == cyc) begin
          eo  = oq[i].pop_front();
          got = '{de: de[i], hs: hsy[i], vs: vsy[i], fs: fs[i],
                  r: red[i], g: grn[i], b: blu[i]};
          check($sformatf("outputs{de,hs,vs,fs,r,g,b} p%0d @%0d", presc(i), cyc),
                64'(got), 64'(eo.o));
        end
      end
    end
  end

  initial begin
    int unsigned r;
    rst = 1'b1; en = 1'b0; fb_base_wr = 1'b0; fb_base = '0; mem_const = 1'b0;
    started = 1'b0; cyc = 0; n_pass = 0; n_total = 0;
    for (int i = 0; i < NI; i++) begin
      k[i] = 0; pend[i] = '0; base[i] = '0; nxt[i] = idle_out();
    end
    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Base 0x100, then run two slow frames.
    fb_base = 32'h100; fb_base_wr = 1'b1;
    cycle();
    repeat (3) cycle();
    en = 1'b1;
    repeat (2 * P1 * FRAME) cycle();

    // Mid-frame base write: takes effect at the next frame only.
    repeat (20) cycle();
    fb_base = 32'h200; fb_base_wr = 1'b1;
    cycle();
    repeat (2 * P1 * FRAME) cycle();

    // Write landing exactly on the fast instance's origin tick.
    for (int w = 0; w < int'(P1 * FRAME) && !origin_tick_now(0); w++) cycle();
    fb_base = 32'h300; fb_base_wr = 1'b1;
    cycle();
    repeat (P1 * FRAME) cycle();

    // Constant colour frame.
    mem_const = 1'b1;
    repeat (P1 * FRAME) cycle();
    mem_const = 1'b0;

    // Reset on line 1 of the fast instance, then restart.
    for (int w = 0; w < int'(FRAME) && ((k[0] % FRAME) / HT != 1); w++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; en = 1'b0;
    repeat (2) cycle();
    en = 1'b1;
    repeat (2 * P1 * FRAME) cycle();

    // Random enables, resets and base writes.
    repeat (1500) begin
      r   = $urandom_range(0, 199);
      rst = 1'b0;
      if (r < 3) en = ~en;
      else if (r == 3) rst = 1'b1;
      else if (r >= 180) begin
        fb_base    = $urandom;
        fb_base_wr = 1'b1;
      end
      cycle();
    end
    rst = 1'b0; en = 1'b0;
    repeat (4) cycle();

    for (int i = 0; i < NI; i++) begin
      check($sformatf("outstanding pixel requests p%0d", presc(i)), 64'(rq[i].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
